frame_writer: RTL and testbench

Ingress-side writer for the packet filter's frame/sideband buffer pair. It accepts AXI-stream frames from the ingress port and writes each beat into the frame buffer. It commits one sideband entry per completed frame, holding the frame's end pointer and destination. It also raises `scan_payload` once the header has passed. It rewinds the frame buffer write pointer to discard a frame on a filter drop or on buffer overflow. The egress-side switch requester drains what this block writes.

---
 rtl/frame_writer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_frame_writer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_writer.sv
// ---------------------------------------------------------------------------
// frame_writer
//
// Ingress-side writer for the frame/sideband buffer pair. Every accepted
// AXI-stream beat is written into the frame buffer in the same cycle. Each
// completed frame gets one sideband entry holding its end pointer and
// destination. A frame that the filter drops, or that overflows the buffer,
// is discarded by rewinding the buffer write pointer to the frame start.
//
// Optional feature macro: FRAME_STATS_EN
//   defined   -> saturating 16-bit frame_ok / frame_drop counters
//   undefined -> stat ports tied to zero, no counter logic
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   ingress_source    upstream beat: tdata[15:0], tdest, tvalid, tlast
//   ingress_sink      tready to upstream
//   drop_req          filter verdict: discard the current frame
//   scan_payload      current frame is past its header
//   frame_wptr        frame buffer write pointer (wrap bit included)
//   frame_full        frame buffer full
//   frame_wen         frame buffer write strobe (same cycle as handshake)
//   frame_wdata       {3'b0, tlast, tdata}
//   frame_wrst        one-cycle pulse: buffer loads pointer from frame_rst_wptr
//   frame_rst_wptr    start pointer of the current frame
//   sideband_full     sideband buffer full
//   sideband_wen      sideband write strobe (one-cycle registered pulse)
//   sideband_wdata    {end pointer, tdest}, upper bits zero
//   stat_frames_ok    committed frame count
//   stat_frames_drop  aborted frame count
//   fsm_state         current controller state (debug observation)
//
// Handshake: a beat transfers on a rising clk edge where tvalid & tready are
// both high. tvalid does not depend on tready; tready depends only on the
// state, the buffer-full input and the pending rewind, never on tvalid.
// ---------------------------------------------------------------------------

package frame_writer_pkg;
  localparam int AXIS_DATA_WIDTH = 16;
  localparam int AXIS_DEST_WIDTH = 4;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] tdata;
    logic [AXIS_DEST_WIDTH-1:0] tdest;
    logic                       tvalid;
    logic                       tlast;
  } axis_d_source_t;

  typedef struct packed {
    logic tready;
  } axis_d_sink_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_DROP    = 3'd4
  } fw_state_t;
endpackage

module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int ADDR_WIDTH   = 11,
  parameter int HEADER_BEATS = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  axis_d_source_t        ingress_source,
  output axis_d_sink_t          ingress_sink,
  input  logic                  drop_req,
  output logic                  scan_payload,
  input  logic [ADDR_WIDTH:0]   frame_wptr,
  input  logic                  frame_full,
  output logic                  frame_wen,
  output logic [19:0]           frame_wdata,
  output logic                  frame_wrst,
  output logic [ADDR_WIDTH:0]   frame_rst_wptr,
  input  logic                  sideband_full,
  output logic                  sideband_wen,
  output logic [19:0]           sideband_wdata,
  output logic [15:0]           stat_frames_ok,
  output logic [15:0]           stat_frames_drop,
  output fw_state_t             fsm_state
);

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  fw_state_t                  state_q, state_d;
  logic [7:0]                 beat_cnt_q, beat_cnt_d;
  logic [AXIS_DEST_WIDTH-1:0] dest_q, dest_d;
  logic [ADDR_WIDTH:0]        rst_wptr_q, rst_wptr_d;
  logic                       scan_q, scan_d;
  logic                       wrst_q, wrst_d;
  logic                       sb_wen_q, sb_wen_d;

  logic                       tready;
  logic                       hs;
  logic                       wen;
  logic                       abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      dest_q     <= '0;
      rst_wptr_q <= '0;
      scan_q     <= 1'b0;
      wrst_q     <= 1'b0;
      sb_wen_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      dest_q     <= dest_d;
      rst_wptr_q <= rst_wptr_d;
      scan_q     <= scan_d;
      wrst_q     <= wrst_d;
      sb_wen_q   <= sb_wen_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / output logic
  //
  // sideband_wen is a registered pulse that must land in the first COMMIT
  // cycle when the sideband buffer has room. It is therefore scheduled one
  // cycle early from the current sideband_full. This is safe because only
  // this block writes the sideband buffer, so full cannot rise between the
  // sample and the write.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    dest_d     = dest_q;
    rst_wptr_d = rst_wptr_q;
    scan_d     = scan_q;
    wrst_d     = 1'b0;
    sb_wen_d   = 1'b0;
    tready     = 1'b0;
    hs         = 1'b0;
    wen        = 1'b0;
    abort      = 1'b0;

    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          // While the rewind pulse is out, the buffer reloads its pointer;
          // hold off the next frame so its start pointer is the rewound one.
          tready = ~frame_full & ~wrst_q;
          hs     = ingress_source.tvalid & tready;
          if (hs) begin
            wen        = 1'b1;
            dest_d     = ingress_source.tdest;
            rst_wptr_d = frame_wptr;
            beat_cnt_d = 8'd1;
            if (ingress_source.tlast) begin
              state_d  = ST_COMMIT;
              sb_wen_d = ~sideband_full;
            end else if (HEADER_BEATS == 1) begin
              state_d = ST_PAYLOAD;
              scan_d  = 1'b1;
            end else begin
              state_d = ST_HEADER;
            end
          end
        end

        ST_HEADER, ST_PAYLOAD: begin
          tready = ~frame_full;
          hs     = ingress_source.tvalid & tready;
          abort  = drop_req | (frame_full & ingress_source.tvalid);
          if (abort) begin
            // A beat accepted in the abort cycle is discarded, not written.
            wrst_d  = 1'b1;
            scan_d  = 1'b0;
            state_d = (hs & ingress_source.tlast) ? ST_IDLE : ST_DROP;
          end else if (hs) begin
            wen = 1'b1;
            if (ingress_source.tlast) begin
              state_d  = ST_COMMIT;
              sb_wen_d = ~sideband_full;
            end else if (state_q == ST_HEADER) begin
              beat_cnt_d = beat_cnt_q + 8'd1;
              if (beat_cnt_q == 8'(HEADER_BEATS - 1)) begin
                state_d = ST_PAYLOAD;
                scan_d  = 1'b1;
              end
            end
          end
        end

        ST_COMMIT: begin
          if (sb_wen_q) begin
            state_d = ST_IDLE;
            scan_d  = 1'b0;
          end else begin
            sb_wen_d = ~sideband_full;
          end
        end

        ST_DROP: begin
          tready = 1'b1;
          hs     = ingress_source.tvalid;
          if (hs && ingress_source.tlast) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ingress_sink   = '{tready: tready};
  assign frame_wen      = wen;
  assign frame_wdata    = wen ? {3'b000, ingress_source.tlast, ingress_source.tdata} : 20'd0;
  assign frame_wrst     = wrst_q;
  assign frame_rst_wptr = rst_wptr_q;
  assign scan_payload   = scan_q;
  assign sideband_wen   = sb_wen_q;
  // No writes happen in COMMIT, so frame_wptr is already one past the last beat.
  assign sideband_wdata = sb_wen_q ? 20'({frame_wptr, dest_q}) : 20'd0;
  assign fsm_state      = state_q;

  // -------------------------------------------------------------------------
  // Frame statistics
  // -------------------------------------------------------------------------
`ifdef FRAME_STATS_EN
  logic [15:0] ok_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ok_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (sb_wen_q && (ok_cnt_q != 16'hFFFF)) begin
        ok_cnt_q <= ok_cnt_q + 16'd1;
      end
      if (wrst_d && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign stat_frames_ok   = ok_cnt_q;
  assign stat_frames_drop = drop_cnt_q;
`else
  assign stat_frames_ok   = 16'd0;
  assign stat_frames_drop = 16'd0;
`endif

endmodule

// File: tb/tb_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_frame_writer
//
// Bench for frame_writer. A small frame-buffer model follows the DUT strobes
// (pointer advance, rewind, memory writes); a negedge monitor logs handshakes,
// writes, rewinds, sideband entries and scan_payload rises. A reference model
// works per frame: from the frame length, destination and abort point it
// derives the expected write count, sideband entry, rewind pointer, scan
// timing and the pointer after the frame.
// ---------------------------------------------------------------------------
module tb_frame_writer;
  import frame_writer_pkg::*;

  localparam int AW = 11;
  localparam int HB = 7;
`ifdef FRAME_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT signals
  axis_d_source_t src;
  axis_d_sink_t   snk;
  logic           drop_req, scan_payload, frame_full, frame_wen, frame_wrst;
  logic [19:0]    frame_wdata, sideband_wdata;
  logic [AW:0]    wptr, frame_rst_wptr;
  logic           sideband_full, sideband_wen;
  logic [15:0]    stat_frames_ok, stat_frames_drop;
  fw_state_t      fsm_state;

  frame_writer #(.ADDR_WIDTH(AW), .HEADER_BEATS(HB)) dut (
    .clk              (clk),
    .reset            (reset),
    .ingress_source   (src),
    .ingress_sink     (snk),
    .drop_req         (drop_req),
    .scan_payload     (scan_payload),
    .frame_wptr       (wptr),
    .frame_full       (frame_full),
    .frame_wen        (frame_wen),
    .frame_wdata      (frame_wdata),
    .frame_wrst       (frame_wrst),
    .frame_rst_wptr   (frame_rst_wptr),
    .sideband_full    (sideband_full),
    .sideband_wen     (sideband_wen),
    .sideband_wdata   (sideband_wdata),
    .stat_frames_ok   (stat_frames_ok),
    .stat_frames_drop (stat_frames_drop),
    .fsm_state        (fsm_state)
  );

  // Monitor: samples on the falling edge, logs events by cycle number
  int          cyc = 0;
  int          hs_cnt = 0;
  int          wen_cnt = 0;
  int          hs_cyc_log[$];
  int          sb_cyc_log[$];
  int          scan_rise_log[$];
  logic [19:0] sb_log[$];
  logic [AW:0] rst_log[$];
  logic        scan_prev = 1'b0;
  logic        pend_wen = 1'b0, pend_wrst = 1'b0;
  logic [19:0] pend_wdata = '0;
  logic [AW:0] pend_rptr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    pend_wen   = frame_wen;
    pend_wdata = frame_wdata;
    pend_wrst  = frame_wrst;
    pend_rptr  = frame_rst_wptr;
    if (frame_wrst) rst_log.push_back(frame_rst_wptr);
    if (sideband_wen) begin
      sb_log.push_back(sideband_wdata);
      sb_cyc_log.push_back(cyc);
    end
    if (scan_payload && !scan_prev) scan_rise_log.push_back(cyc);
    scan_prev = scan_payload;
    if (!reset) begin
      if (src.tvalid && snk.tready) begin
        hs_cnt++;
        hs_cyc_log.push_back(cyc);
      end
      if (frame_wen) wen_cnt++;
    end
  end

  // Frame buffer model: owns the write pointer and the memory
  logic [19:0] mem [0:(1<<AW)-1];
  logic        load_req = 1'b0;
  logic [AW:0] load_val = '0;

  always @(posedge clk) begin
    if (reset) wptr <= '0;
    else if (load_req) wptr <= load_val;
    else if (pend_wrst) wptr <= pend_rptr;
    else if (pend_wen) begin
      mem[wptr[AW-1:0]] <= pend_wdata;
      wptr <= wptr + 1'b1;
    end
  end

  // Scoreboard state
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [AW:0] exp_ptr;
  int          exp_ok = 0;
  int          exp_drop = 0;
  logic [15:0] frm_data [0:63];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] exp_sb(input logic [AW:0] p, input logic [3:0] d);
    return {4'b0, p, d};
  endfunction

  task automatic preset_wptr(input logic [AW:0] v);
    load_val = v;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    exp_ptr  = v;
  endtask

  // Drives one frame. drop_beat / full_beat (2..n, 0 = none) pick the beat on
  // which drop_req or frame_full is raised; sbf_hold is the number of cycles
  // sideband_full is high starting with the tlast handshake cycle.
  task automatic send_frame(input int n, input logic [3:0] dest, input int drop_beat,
                            input int full_beat, input int sbf_hold, input int gap_max,
                            input string tag);
    logic [AW:0] start;
    int hs0, wen0, sb0, rst0, scan0, hsc0, exp_w;
    bit acc, committed;
    start = exp_ptr;
    hs0 = hs_cnt; wen0 = wen_cnt; sb0 = sb_log.size(); rst0 = rst_log.size();
    scan0 = scan_rise_log.size(); hsc0 = hs_cyc_log.size();
    committed = (drop_beat == 0) && (full_beat == 0);
    for (int i = 0; i < n; i++) frm_data[i] = 16'($urandom);

    for (int b = 1; b <= n; b++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      src.tvalid    = 1'b1;
      src.tdata     = frm_data[b-1];
      src.tlast     = (b == n);
      src.tdest     = dest;
      drop_req      = (b == drop_beat);
      frame_full    = (b == full_beat);
      sideband_full = (b == n) && (sbf_hold > 0);
      acc = 1'b0;
      for (int g = 0; g < 50 && !acc; g++) begin
        @(negedge clk);
        acc = snk.tready;
        @(posedge clk); #1;
        drop_req   = 1'b0;
        frame_full = 1'b0;
      end
      check({tag, "_beat_accepted"}, 32'(acc), 32'd1);
      src.tvalid = 1'b0;
      src.tlast  = 1'b0;
    end

    for (int j = 1; j < sbf_hold; j++) begin
      @(negedge clk);
      check({tag, "_stall_tready"}, 32'(snk.tready), 32'd0);
      @(posedge clk); #1;
    end
    sideband_full = 1'b0;

    acc = 1'b0;
    for (int g = 0; g < 40 && !acc; g++) begin
      @(negedge clk);
      acc = (fsm_state == ST_IDLE);
      @(posedge clk); #1;
    end
    check({tag, "_back_to_idle"}, 32'(acc), 32'd1);

    exp_w = committed ? n : ((drop_beat != 0) ? drop_beat - 1 : full_beat - 1);
    check({tag, "_handshakes"}, 32'(hs_cnt - hs0), 32'(n));
    check({tag, "_writes"}, 32'(wen_cnt - wen0), 32'(exp_w));
    if (committed) begin
      check({tag, "_sb_count"}, 32'(sb_log.size() - sb0), 32'd1);
      check({tag, "_rewinds"}, 32'(rst_log.size() - rst0), 32'd0);
      if (sb_log.size() > sb0 && hs_cyc_log.size() >= hsc0 + n) begin
        check({tag, "_sb_entry"}, 32'(sb_log[sb0]), 32'(exp_sb(start + AW'(n), dest)));
        check({tag, "_sb_latency"}, 32'(sb_cyc_log[sb0]), 32'(hs_cyc_log[hsc0+n-1] + sbf_hold + 1));
      end
      for (int i = 0; i < n; i++) begin
        logic [AW:0] a;
        a = start + (AW+1)'(i);
        check({tag, "_mem"}, 32'(mem[a[AW-1:0]]), 32'({3'b0, (i == n-1), frm_data[i]}));
      end
      if (n > HB) begin
        check({tag, "_scan_rises"}, 32'(scan_rise_log.size() - scan0), 32'd1);
        if (scan_rise_log.size() > scan0 && hs_cyc_log.size() >= hsc0 + HB)
          check({tag, "_scan_cycle"}, 32'(scan_rise_log[scan0]), 32'(hs_cyc_log[hsc0+HB-1] + 1));
      end else begin
        check({tag, "_scan_never"}, 32'(scan_rise_log.size() - scan0), 32'd0);
      end
      exp_ptr = start + (AW+1)'(n);
      exp_ok++;
    end else begin
      check({tag, "_sb_count"}, 32'(sb_log.size() - sb0), 32'd0);
      check({tag, "_rewinds"}, 32'(rst_log.size() - rst0), 32'd1);
      if (rst_log.size() > rst0)
        check({tag, "_rewind_ptr"}, 32'(rst_log[rst0]), 32'(start));
      exp_drop++;
    end
    check({tag, "_wptr_after"}, 32'(wptr), 32'(exp_ptr));
    check({tag, "_scan_low_idle"}, 32'(scan_payload), 32'd0);
    check({tag, "_stat_ok"}, 32'(stat_frames_ok), STATS_EN ? 32'(exp_ok) : 32'd0);
    check({tag, "_stat_drop"}, 32'(stat_frames_drop), STATS_EN ? 32'(exp_drop) : 32'd0);
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_state"}, 32'(fsm_state), 32'(ST_IDLE));
    check({tag, "_tready"}, 32'(snk.tready), 32'd0);
    check({tag, "_frame_wen"}, 32'(frame_wen), 32'd0);
    check({tag, "_frame_wrst"}, 32'(frame_wrst), 32'd0);
    check({tag, "_sideband_wen"}, 32'(sideband_wen), 32'd0);
    check({tag, "_scan"}, 32'(scan_payload), 32'd0);
    check({tag, "_rst_wptr"}, 32'(frame_rst_wptr), 32'd0);
    check({tag, "_sb_wdata"}, 32'(sideband_wdata), 32'd0);
    check({tag, "_stat_ok"}, 32'(stat_frames_ok), 32'd0);
    check({tag, "_stat_drop"}, 32'(stat_frames_drop), 32'd0);
  endtask

  // Directed steps followed by randomized frames
  initial begin
    int rst0, hs0;
    src = '0; drop_req = 1'b0; frame_full = 1'b0; sideband_full = 1'b0;
    reset = 1'b1;
    exp_ptr = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_quiet_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_wptr", 32'(wptr), 32'd0);

    // 10-beat frame across the address wrap, dest 3
    preset_wptr(12'h7FC);
    send_frame(10, 4'd3, 0, 0, 0, 0, "frame10");
    if (sb_log.size() > 0)
      check("frame10_end_0x806", 32'(sb_log[0]), 32'h08063);

    // Filter drop on beat 4 of a 12-beat frame
    send_frame(12, 4'd6, 4, 0, 0, 0, "drop4");

    // Overflow mid-payload, then a normal frame from the rewound pointer
    send_frame(14, 4'd9, 0, 10, 0, 0, "overflow");
    send_frame(9, 4'd1, 0, 0, 0, 0, "after_overflow");

    // Sideband buffer full for 5 cycles at tlast
    send_frame(8, 4'd12, 0, 0, 5, 0, "sb_full");

    // Single-beat frame
    send_frame(1, 4'd15, 0, 0, 0, 0, "single");

    // Drop coinciding with the tlast beat
    send_frame(5, 4'd2, 5, 0, 0, 0, "drop_last");

    // Reset while in PAYLOAD
    rst0 = rst_log.size();
    hs0  = hs_cnt;
    src.tdest = 4'd5;
    for (int b = 0; b < 9; b++) begin
      src.tvalid = 1'b1;
      src.tdata  = 16'($urandom);
      src.tlast  = 1'b0;
      @(posedge clk); #1;
    end
    src.tvalid = 1'b0;
    check("midreset_beats", 32'(hs_cnt - hs0), 32'd9);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_quiet_outputs("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_no_rewind", 32'(rst_log.size() - rst0), 32'd0);
    check("midreset_wptr", 32'(wptr), 32'd0);
    exp_ptr = '0; exp_ok = 0; exp_drop = 0;

    // Randomized frames with gaps, aborts and sideband back-pressure
    for (int f = 0; f < 30; f++) begin
      int n, mode, db, fb, hold;
      n = $urandom_range(1, 16);
      mode = $urandom_range(0, 9);
      db = 0; fb = 0; hold = 0;
      if (n >= 2 && mode < 2) db = $urandom_range(2, n);
      else if (n >= 2 && mode < 4) fb = $urandom_range(2, n);
      else hold = $urandom_range(0, 3);
      send_frame(n, 4'($urandom_range(0, 15)), db, fb, hold, 2, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
